regdct_pingpong: RTL and testbench



---
 rtl/regdct_pingpong_if.sv | 29 ++
 rtl/regdct_pingpong.sv | 109 ++++++++++
 tb/tb_regdct_pingpong.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/regdct_pingpong_if.sv
// Handshake bundle between the front-end writer, the ping-pong
// coefficient store and the back-end reader.
interface regdct_pingpong_if #(
    parameter int DW = 16,
    parameter int AW = 5
);
    logic          flush;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          wr_drop;
    logic          frame_done;
    logic          rd_avail;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_release;

    modport master (
        output flush, wr_valid, wr_data, rd_en, rd_addr, rd_release,
        input  wr_ready, wr_drop, frame_done, rd_avail, rd_data, rd_valid
    );

    modport slave (
        input  flush, wr_valid, wr_data, rd_en, rd_addr, rd_release,
        output wr_ready, wr_drop, frame_done, rd_avail, rd_data, rd_valid
    );
endinterface

// File: rtl/regdct_pingpong.sv
// Two-bank ping-pong coefficient store for the MFCC feature path.
// The writer streams FRAME_LEN words into one bank while the reader
// consumes the previously completed frame from the other bank.
module regdct_pingpong #(
    parameter int DW        = 16,
    parameter int AW        = 5,
    parameter int FRAME_LEN = 23
) (
    input logic             clk,
    input logic             reset,
    regdct_pingpong_if.slave bus
);
    localparam int          DEPTH  = 2 ** AW;
    localparam int unsigned NWORDS = 2 * DEPTH;

    // Bank index is the top address bit: {bank, word}.
    logic [DW-1:0] mem [NWORDS];

    logic          wbank;
    logic          rbank;
    logic [AW-1:0] wptr;
    logic [1:0]    bank_full;
    logic [1:0]    bank_full_nxt;

    logic wr_ready_i;
    logic rd_avail_i;
    logic wr_accept;
    logic wr_last;
    logic rd_fire;
    logic rel_fire;
    logic drop_now;

    // Ownership-derived handshakes and the qualified events of this cycle.
    always_comb begin
        wr_ready_i = !bank_full[wbank];
        rd_avail_i = bank_full[rbank];
        wr_accept  = !bus.flush && bus.wr_valid && wr_ready_i;
        wr_last    = (wptr == AW'(FRAME_LEN - 1));
        rd_fire    = !bus.flush && bus.rd_en && rd_avail_i;
        rel_fire   = !bus.flush && bus.rd_release && rd_avail_i;
        drop_now   = !bus.flush && bus.wr_valid && !wr_ready_i;

        // Completing a frame and releasing the other bank never target the
        // same bank, so both updates can be applied together.
        bank_full_nxt = bank_full;
        if (wr_accept && wr_last) bank_full_nxt[wbank] = 1'b1;
        if (rel_fire)             bank_full_nxt[rbank] = 1'b0;

        bus.wr_ready = wr_ready_i;
        bus.rd_avail = rd_avail_i;
    end

    // Write pointer, bank selectors and full flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            wptr      <= '0;
            bank_full <= '0;
        end else if (bus.flush) begin
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            wptr      <= '0;
            bank_full <= '0;
        end else begin
            if (wr_accept) begin
                if (wr_last) begin
                    wptr  <= '0;
                    wbank <= ~wbank;
                end else begin
                    wptr <= wptr + AW'(1);
                end
            end
            if (rel_fire) rbank <= ~rbank;
            bank_full <= bank_full_nxt;
        end
    end

    // Coefficient storage; cleared only by reset, never by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NWORDS; i++) mem[i] <= '0;
        end else if (wr_accept) begin
            mem[{wbank, wptr}] <= bus.wr_data;
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.wr_drop    <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.rd_valid   <= 1'b0;
        end else begin
            bus.wr_drop    <= drop_now;
            bus.frame_done <= wr_accept && wr_last;
            bus.rd_valid   <= rd_fire;
        end
    end

    // Registered read port; samples rbank before any same-cycle release swap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rd_data <= '0;
        end else if (rd_fire) begin
            bus.rd_data <= mem[{rbank, bus.rd_addr}];
        end
    end
endmodule

// File: tb/tb_regdct_pingpong.sv
// Randomised bench for regdct_pingpong against a frame-queue reference model.
module tb_regdct_pingpong;
    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int FL    = 23;
    localparam int DEPTH = 2 ** AW;

    logic clk;
    logic reset;

    regdct_pingpong_if #(.DW(DW), .AW(AW)) bus ();

    regdct_pingpong #(.DW(DW), .AW(AW), .FRAME_LEN(FL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: contents of both banks, the bank currently being
    // filled, and a FIFO of completed banks (oldest one owned by the reader).
    logic [DW-1:0] m_mem [2][DEPTH];
    int            m_wb;
    int            m_wp;
    int            done_q[$];
    logic          e_drop, e_done, e_rv;
    logic [DW-1:0] e_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) m_mem[b][a] = '0;
        m_wb = 0; m_wp = 0; done_q.delete();
        e_drop = 0; e_done = 0; e_rv = 0; e_rd = '0;
    endfunction

    function automatic void model_step(input logic f, input logic wv, input logic [DW-1:0] wd,
                                       input logic re, input logic [AW-1:0] ra, input logic rr);
        bit ready, avail;
        if (f) begin
            m_wb = 0; m_wp = 0; done_q.delete();
            e_drop = 0; e_done = 0; e_rv = 0;
            return;
        end
        ready = (done_q.size() < 2);
        avail = (done_q.size() > 0);
        e_rv  = re && avail;
        if (re && avail) e_rd = m_mem[done_q[0]][ra];
        e_drop = wv && !ready;
        e_done = 0;
        if (rr && avail) void'(done_q.pop_front());
        if (wv && ready) begin
            m_mem[m_wb][m_wp] = wd;
            m_wp++;
            if (m_wp == FL) begin
                m_wp = 0;
                done_q.push_back(m_wb);
                m_wb ^= 1;
                e_done = 1;
            end
        end
    endfunction

    task automatic check_outputs();
        check_eq("wr_ready",   bus.wr_ready,   done_q.size() < 2);
        check_eq("rd_avail",   bus.rd_avail,   done_q.size() > 0);
        check_eq("wr_drop",    bus.wr_drop,    e_drop);
        check_eq("frame_done", bus.frame_done, e_done);
        check_eq("rd_valid",   bus.rd_valid,   e_rv);
        check_eq("rd_data",    bus.rd_data,    e_rd);
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic cycle(input logic f, input logic wv, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic rr);
        bus.flush = f; bus.wr_valid = wv; bus.wr_data = wd;
        bus.rd_en = re; bus.rd_addr = ra; bus.rd_release = rr;
        @(posedge clk);
        model_step(f, wv, wd, re, ra, rr);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wr(input int v);
        cycle(1'b0, 1'b1, DW'(v), 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input int a, input logic rel);
        cycle(1'b0, 1'b0, '0, 1'b1, AW'(a), rel);
    endtask

    initial begin
        clk = 0;
        reset = 0;
        bus.flush = 0; bus.wr_valid = 0; bus.wr_data = '0;
        bus.rd_en = 0; bus.rd_addr = '0; bus.rd_release = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1;

        // Fill bank 0 with 1..23 and read it back, including an unwritten tail word.
        for (int i = 1; i <= FL; i++) begin
            if (i == FL) check_eq("avail_before_fill", bus.rd_avail, 0);
            wr(i);
        end
        check_eq("done_pulse", bus.frame_done, 1);
        check_eq("avail_after_fill", bus.rd_avail, 1);
        rd(0, 0);
        check_eq("rd_addr0", bus.rd_data, 1);
        check_eq("done_once", bus.frame_done, 0);
        rd(22, 0);
        check_eq("rd_addr22", bus.rd_data, 23);
        rd(31, 0);
        check_eq("rd_addr31", bus.rd_data, 0);

        // Fill bank 1 without releasing, then hit backpressure.
        for (int i = 101; i <= 123; i++) wr(i);
        check_eq("bp_ready", bus.wr_ready, 0);
        wr(200);
        check_eq("bp_drop", bus.wr_drop, 1);
        rd(5, 1);
        check_eq("rd_during_release", bus.rd_data, 6);
        check_eq("avail_bank1", bus.rd_avail, 1);
        check_eq("ready_after_release", bus.wr_ready, 1);
        rd(0, 0);
        check_eq("rd_bank1", bus.rd_data, 101);

        // Partial frame, flush, then a full frame 50..72.
        rd(0, 1);
        for (int i = 0; i < 10; i++) wr(1000 + i);
        cycle(1'b1, 1'b1, 16'h7777, 1'b1, '0, 1'b1);
        for (int i = 50; i <= 72; i++) wr(i);
        check_eq("flush_done", bus.frame_done, 1);
        rd(0, 0);
        check_eq("flush_rd0", bus.rd_data, 50);

        // Reset in the middle of a frame.
        for (int i = 0; i < 12; i++) wr($urandom_range(1, 65535));
        rd(0, 0);
        #2 reset = 0;
        #1;
        check_eq("rst_drop",  bus.wr_drop, 0);
        check_eq("rst_done",  bus.frame_done, 0);
        check_eq("rst_valid", bus.rd_valid, 0);
        check_eq("rst_data",  bus.rd_data, 0);
        check_eq("rst_avail", bus.rd_avail, 0);
        check_eq("rst_ready", bus.wr_ready, 1);
        model_reset();
        @(negedge clk);
        reset = 1;
        for (int i = 301; i <= 323; i++) wr(i);
        check_eq("post_rst_done", bus.frame_done, 1);
        rd(0, 0);
        check_eq("post_rst_rd0", bus.rd_data, 301);
        rd(31, 0);
        check_eq("post_rst_rd31", bus.rd_data, 0);

        // Random traffic with frequent backpressure and occasional flush.
        repeat (3000) begin
            cycle($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 75,
                  DW'($urandom),
                  $urandom_range(0, 99) < 50,
                  AW'($urandom_range(0, DEPTH - 1)),
                  $urandom_range(0, 99) < 8);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
